// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a show-ahead byte FIFO; byte visible 1 cycle after the stop-bit sample.
// No backpressure to the line: a good byte arriving at a full FIFO (without a same-cycle pop) is dropped and flagged.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       RXD,
  input  logic       rd_en,
  input  logic       clr_err,
  output logic [7:0] data_o,
  output logic       empty_o,
  output logic       full_o,
  output logic       busy_o,
  output logic       frame_err_o,
  output logic       overrun_o
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] HALF_BIT = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t          state_q, state_d;
  logic            rx_meta_q, rx_s_q, rx_d_q;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic [2:0]      bitidx_q, bitidx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      mem_d [FIFO_DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            tick, push, pop, do_push, fifo_full, fifo_empty;

  assign tick = (bcnt_q == BIT_LAST);

  always_comb begin
    state_d     = state_q;
    bcnt_d      = tick ? '0 : bcnt_q + 1'b1;
    bitidx_d    = bitidx_q;
    shreg_d     = shreg_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_d_q && !rx_s_q) state_d = START;
      end
      START: begin
        bitidx_d = '0;
        if (bcnt_q == HALF_BIT) state_d = rx_s_q ? IDLE : DATA;
      end
      DATA: begin
        if (tick) begin
          shreg_d[bitidx_q] = rx_s_q;
          bitidx_d          = bitidx_q + 3'd1;
          if (bitidx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          if (rx_s_q) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Every state entry restarts bit timing from zero.
    if (state_d != state_q) bcnt_d = '0;
  end

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign pop        = rd_en && !fifo_empty;
  assign do_push    = push && (!fifo_full || pop);

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) begin
      mem_d[wptr_q] = shreg_q;
      wptr_d        = wptr_q + 1'b1;
    end
    if (pop) rptr_d = rptr_q + 1'b1;
    if (do_push && !pop) count_d = count_q + 1'b1;
    else if (pop && !do_push) count_d = count_q - 1'b1;
    // A new overrun outranks a simultaneous clear.
    if (push && fifo_full && !pop) overrun_d = 1'b1;
    else if (clr_err) overrun_d = 1'b0;
    else overrun_d = overrun_q;
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q     <= IDLE;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_d_q      <= 1'b1;
      bcnt_q      <= '0;
      bitidx_q    <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      mem_q       <= '{default: '0};
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= RXD;
      rx_s_q      <= rx_meta_q;
      rx_d_q      <= rx_s_q;
      bcnt_q      <= bcnt_d;
      bitidx_q    <= bitidx_d;
      shreg_q     <= shreg_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      mem_q       <= mem_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
    end
  end

  assign data_o      = mem_q[rptr_q];
  assign empty_o     = fifo_empty;
  assign full_o      = fifo_full;
  assign busy_o      = (state_q != IDLE);
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 16 clocks per bit and a 16-byte FIFO.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       RST = 1'b1;
  logic       RXD = 1'b1;
  logic       rd_en = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] data_o;
  logic       empty_o, full_o, busy_o, frame_err_o, overrun_o;

  int n_cmp = 0;
  int n_bad = 0;

  uart_rx_fifo #(.CLKS_PER_BIT(16), .FIFO_DEPTH(16)) dut (
    .clk(clk), .RST(RST), .RXD(RXD), .rd_en(rd_en), .clr_err(clr_err),
    .data_o(data_o), .empty_o(empty_o), .full_o(full_o), .busy_o(busy_o),
    .frame_err_o(frame_err_o), .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  // Called at a negedge; returns 160 clocks later. The push lands on the 155th posedge.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    RXD = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RXD = b[i];
      repeat (16) @(negedge clk);
    end
    RXD = stop_bit;
    repeat (16) @(negedge clk);
  endtask

  task automatic test_reset;
    RST = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (empty_o !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %b expected 1", empty_o); end
    n_cmp++; if (full_o !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b expected 0", full_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    n_cmp++; if (frame_err_o !== 1'b0) begin n_bad++; $display("FAIL reset_ferr: got %b expected 0", frame_err_o); end
    n_cmp++; if (overrun_o !== 1'b0) begin n_bad++; $display("FAIL reset_ovr: got %b expected 0", overrun_o); end
    n_cmp++; if (data_o !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h expected 00", data_o); end
    RST = 1'b0;
    repeat (4) @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    @(negedge clk);
    n_cmp++; if (empty_o !== 1'b1 || full_o !== 1'b0) begin n_bad++; $display("FAIL pop_when_empty: got empty=%b full=%b expected 1 0", empty_o, full_o); end
  endtask

  task automatic test_single_byte;
    int got = 0;
    int ferr = 0;
    int ovr = 0;
    fork
      send_frame(8'hA5, 1'b1);
      for (int c = 1; c <= 200; c++) begin
        @(negedge clk);
        if (frame_err_o) ferr++;
        if (overrun_o) ovr++;
        if (!empty_o && got == 0) got = c;
      end
    join
    n_cmp++; if (got == 0 || got > 155) begin n_bad++; $display("FAIL a5_latency: got %0d cycles expected 1..155", got); end
    n_cmp++; if (data_o !== 8'hA5) begin n_bad++; $display("FAIL a5_data: got %h expected a5", data_o); end
    n_cmp++; if (ferr != 0 || ovr != 0) begin n_bad++; $display("FAIL a5_flags: got ferr=%0d ovr=%0d expected 0 0", ferr, ovr); end
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    n_cmp++; if (empty_o !== 1'b1) begin n_bad++; $display("FAIL a5_drain: got empty=%b expected 1", empty_o); end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_glitch;
    int saw_busy = 0;
    int clr_at = 0;
    int ferr = 0;
    RXD = 1'b0;
    fork
      begin
        repeat (5) @(negedge clk);
        RXD = 1'b1;
      end
      for (int c = 1; c <= 30; c++) begin
        @(negedge clk);
        if (frame_err_o) ferr++;
        if (busy_o) saw_busy = 1;
        if (saw_busy == 1 && !busy_o && clr_at == 0) clr_at = c;
      end
    join
    n_cmp++; if (saw_busy != 1) begin n_bad++; $display("FAIL glitch_busy_seen: got %0d expected 1", saw_busy); end
    n_cmp++; if (clr_at == 0 || clr_at > 11) begin n_bad++; $display("FAIL glitch_idle_time: got %0d expected 1..11", clr_at); end
    n_cmp++; if (empty_o !== 1'b1 || ferr != 0 || overrun_o !== 1'b0) begin n_bad++; $display("FAIL glitch_no_effect: got empty=%b ferr=%0d ovr=%b expected 1 0 0", empty_o, ferr, overrun_o); end
  endtask

  task automatic test_frame_err;
    int ferr = 0;
    logic busy_low = 1'b0;
    logic busy_after = 1'b1;
    fork
      begin
        send_frame(8'h3C, 1'b0);
        repeat (40) @(negedge clk);
        RXD = 1'b1;
      end
      for (int c = 1; c <= 215; c++) begin
        @(negedge clk);
        if (frame_err_o) ferr++;
        if (c == 199) busy_low = busy_o;
        if (c == 212) busy_after = busy_o;
      end
    join
    n_cmp++; if (ferr != 1) begin n_bad++; $display("FAIL ferr_pulses: got %0d expected 1", ferr); end
    n_cmp++; if (empty_o !== 1'b1) begin n_bad++; $display("FAIL ferr_discard: got empty=%b expected 1", empty_o); end
    n_cmp++; if (busy_low !== 1'b1) begin n_bad++; $display("FAIL ferr_wait_low: got busy=%b expected 1", busy_low); end
    n_cmp++; if (busy_after !== 1'b0) begin n_bad++; $display("FAIL ferr_release: got busy=%b expected 0", busy_after); end
    send_frame(8'h55, 1'b1);
    n_cmp++; if (empty_o !== 1'b0 || data_o !== 8'h55) begin n_bad++; $display("FAIL ferr_next_byte: got empty=%b data=%h expected 0 55", empty_o, data_o); end
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_overrun;
    logic [7:0] b;
    for (int i = 0; i < 16; i++) begin
      b = 8'(i);
      send_frame(b, 1'b1);
      n_cmp++; if (full_o !== (i == 15)) begin n_bad++; $display("FAIL fill_full_%0d: got %b expected %b", i, full_o, (i == 15)); end
    end
    n_cmp++; if (overrun_o !== 1'b0) begin n_bad++; $display("FAIL ovr_early: got %b expected 0", overrun_o); end
    send_frame(8'h10, 1'b1);
    n_cmp++; if (overrun_o !== 1'b1 || full_o !== 1'b1) begin n_bad++; $display("FAIL ovr_set: got ovr=%b full=%b expected 1 1", overrun_o, full_o); end
    for (int i = 0; i < 16; i++) begin
      b = 8'(i);
      n_cmp++; if (empty_o !== 1'b0 || data_o !== b) begin n_bad++; $display("FAIL ovr_read_%0d: got empty=%b data=%h expected 0 %h", i, empty_o, data_o, b); end
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
    end
    n_cmp++; if (empty_o !== 1'b1 || overrun_o !== 1'b1) begin n_bad++; $display("FAIL ovr_drained: got empty=%b ovr=%b expected 1 1", empty_o, overrun_o); end
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    n_cmp++; if (overrun_o !== 1'b0) begin n_bad++; $display("FAIL ovr_clear: got %b expected 0", overrun_o); end
  endtask

  task automatic test_full_pop_push;
    logic [7:0] b;
    logic full_at_push = 1'b0;
    for (int i = 0; i < 16; i++) begin
      b = 8'h20 + 8'(i);
      send_frame(b, 1'b1);
    end
    n_cmp++; if (full_o !== 1'b1) begin n_bad++; $display("FAIL fp_prefill: got full=%b expected 1", full_o); end
    fork
      send_frame(8'h77, 1'b1);
      begin
        repeat (154) @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        full_at_push = full_o;
      end
    join
    n_cmp++; if (full_at_push !== 1'b1 || full_o !== 1'b1) begin n_bad++; $display("FAIL fp_count: got full=%b/%b expected 1/1", full_at_push, full_o); end
    n_cmp++; if (overrun_o !== 1'b0) begin n_bad++; $display("FAIL fp_no_overrun: got %b expected 0", overrun_o); end
    for (int i = 0; i < 16; i++) begin
      b = (i == 15) ? 8'h77 : 8'h21 + 8'(i);
      n_cmp++; if (empty_o !== 1'b0 || data_o !== b) begin n_bad++; $display("FAIL fp_read_%0d: got empty=%b data=%h expected 0 %h", i, empty_o, data_o, b); end
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
    end
    n_cmp++; if (empty_o !== 1'b1) begin n_bad++; $display("FAIL fp_drained: got empty=%b expected 1", empty_o); end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] d_r;
    logic [4:0] f_r;
    int pushes = 0;
    send_frame(8'h42, 1'b1);
    n_cmp++; if (empty_o !== 1'b0 || data_o !== 8'h42) begin n_bad++; $display("FAIL rst_pre: got empty=%b data=%h expected 0 42", empty_o, data_o); end
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (60) @(negedge clk);
        RST = 1'b1;
        @(negedge clk);
        RST = 1'b0;
        d_r = data_o;
        f_r = {empty_o, full_o, busy_o, frame_err_o, overrun_o};
        for (int c = 0; c < 140; c++) begin
          @(negedge clk);
          if (!empty_o || frame_err_o) pushes++;
        end
      end
    join
    n_cmp++; if (d_r !== 8'h00) begin n_bad++; $display("FAIL rst_mid_data: got %h expected 00", d_r); end
    n_cmp++; if (f_r !== 5'b10000) begin n_bad++; $display("FAIL rst_mid_flags: got %b expected 10000", f_r); end
    n_cmp++; if (pushes != 0) begin n_bad++; $display("FAIL rst_mid_residue: got %0d events expected 0", pushes); end
    send_frame(8'h81, 1'b1);
    n_cmp++; if (empty_o !== 1'b0 || data_o !== 8'h81) begin n_bad++; $display("FAIL rst_after_byte: got empty=%b data=%h expected 0 81", empty_o, data_o); end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_single_byte;
    test_glitch;
    test_frame_err;
    test_overrun;
    test_full_pop_push;
    test_reset_mid_frame;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
